// File: rtl/program_loader.sv
`timescale 1ns / 1ps
// program_loader: receives a framed 16-byte program over 8N1 UART, writes it
// into the core's program RAM and holds the core in reset until the frame's
// checksum verifies. A failed load leaves the hold and a sticky error raised.
module program_loader #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 2**20
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       uart_rx_i,
    output logic       load_we_o,
    output logic [3:0] load_addr_o,
    output logic [7:0] load_data_o,
    output logic       cpu_hold_o,
    output logic       load_done_o,
    output logic       load_error_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_CHECK, LD_FAIL} ld_state_t;

    // Receiver-to-loader handshake: rx_valid (good byte in rx_shift) and
    // rx_ferr (bad stop bit) are single-cycle strobes with no ready; the
    // loader consumes every strobe in the cycle it is raised.
    logic            rx_meta, rx_sync;
    rx_state_t       rx_state, rx_state_d;
    logic [CW-1:0]   rx_cnt, rx_cnt_d;
    logic [2:0]      rx_bit, rx_bit_d;
    logic [7:0]      rx_shift, rx_shift_d;
    logic            rx_valid, rx_valid_d;
    logic            rx_ferr, rx_ferr_d;

    ld_state_t       ld_state, ld_state_d;
    logic [3:0]      addr, addr_d;
    logic [7:0]      sum, sum_d;
    logic [TW-1:0]   tcnt, tcnt_d;
    logic            we_d, done_d;
    logic [3:0]      waddr_d;
    logic [7:0]      wdata_d;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state register and its strobes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            rx_valid <= rx_valid_d;
            rx_ferr  <= rx_ferr_d;
        end
    end

    // Receiver next state: mid-bit sampling timed from the synced start edge.
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt + CW'(1);
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync, rx_shift[7:1]};
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rx_sync;
                    rx_ferr_d  = !rx_sync;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Loader state register and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ld_state     <= LD_IDLE;
            addr         <= '0;
            sum          <= '0;
            tcnt         <= '0;
            load_we_o    <= 1'b0;
            load_addr_o  <= '0;
            load_data_o  <= '0;
            cpu_hold_o   <= 1'b0;
            load_done_o  <= 1'b0;
            load_error_o <= 1'b0;
        end else begin
            ld_state     <= ld_state_d;
            addr         <= addr_d;
            sum          <= sum_d;
            tcnt         <= tcnt_d;
            load_we_o    <= we_d;
            load_addr_o  <= waddr_d;
            load_data_o  <= wdata_d;
            cpu_hold_o   <= (ld_state_d != LD_IDLE);
            load_done_o  <= done_d;
            load_error_o <= (ld_state_d == LD_FAIL);
        end
    end

    // Loader next state: frame parsing, RAM writes, checksum and timeout.
    always_comb begin
        ld_state_d = ld_state;
        addr_d     = addr;
        sum_d      = sum;
        tcnt_d     = tcnt;
        we_d       = 1'b0;
        waddr_d    = load_addr_o;
        wdata_d    = load_data_o;
        done_d     = 1'b0;
        case (ld_state)
            LD_IDLE, LD_FAIL: begin
                if (rx_valid && rx_shift == SYNC_BYTE) begin
                    ld_state_d = LD_LOAD;
                    addr_d     = '0;
                    sum_d      = '0;
                    tcnt_d     = '0;
                end
            end
            LD_LOAD: begin
                tcnt_d = tcnt + TW'(1);
                if (rx_ferr) begin
                    ld_state_d = LD_FAIL;
                end else if (rx_valid) begin
                    tcnt_d  = '0;
                    we_d    = 1'b1;
                    waddr_d = addr;
                    wdata_d = rx_shift;
                    sum_d   = sum + rx_shift;
                    addr_d  = addr + 4'd1;
                    if (addr == 4'd15) ld_state_d = LD_CHECK;
                end else if (tcnt == TMO_M1) begin
                    ld_state_d = LD_FAIL;
                end
            end
            LD_CHECK: begin
                tcnt_d = tcnt + TW'(1);
                if (rx_ferr) begin
                    ld_state_d = LD_FAIL;
                end else if (rx_valid) begin
                    tcnt_d = '0;
                    if (rx_shift == sum) begin
                        ld_state_d = LD_IDLE;
                        done_d     = 1'b1;
                    end else begin
                        ld_state_d = LD_FAIL;
                    end
                end else if (tcnt == TMO_M1) begin
                    ld_state_d = LD_FAIL;
                end
            end
            default: ld_state_d = LD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns / 1ps
// Bench for program_loader: directed UART frames, a frame-level model of the
// loader fed by the bytes the bench sends, and a per-cycle compare process.
module tb_program_loader;

    localparam int         CPB  = 4;
    localparam int         TMO  = 200;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       uart_rx_i;
    logic       load_we_o;
    logic [3:0] load_addr_o;
    logic [7:0] load_data_o;
    logic       cpu_hold_o;
    logic       load_done_o;
    logic       load_error_o;

    program_loader #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .uart_rx_i   (uart_rx_i),
        .load_we_o   (load_we_o),
        .load_addr_o (load_addr_o),
        .load_data_o (load_data_o),
        .cpu_hold_o  (cpu_hold_o),
        .load_done_o (load_done_o),
        .load_error_o(load_error_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int         due;
        logic [7:0] b;
        bit         ferr;
    } ev_t;

    ev_t         evq[$];     // bytes on their way through the receiver
    logic [11:0] exp_q[$];   // expected {addr, data} writes

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    bit  m_in_frame = 1'b0;
    bit  m_failed = 1'b0;
    int  m_idx = 0;
    int  m_sum = 0;
    int  tmo_at = -10;
    bit  exp_done = 1'b0;
    int  we_cnt = 0;
    int  done_cnt = 0;
    int  last_we_cyc = 0;
    int  err_rise_cyc = 0;
    logic err_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level rules: sync opens a frame, 16 data bytes, then checksum.
    task automatic model_apply(input ev_t e);
        int rx_cyc;
        rx_cyc = e.due - 1;
        if (e.ferr) begin
            if (m_in_frame) begin
                m_in_frame = 1'b0;
                m_failed   = 1'b1;
                tmo_at     = -10;
            end
        end else if (!m_in_frame) begin
            if (e.b == SYNC) begin
                m_in_frame = 1'b1;
                m_failed   = 1'b0;
                m_idx      = 0;
                m_sum      = 0;
                tmo_at     = rx_cyc + TMO;
            end
        end else if (m_idx < 16) begin
            exp_q.push_back({m_idx[3:0], e.b});
            m_sum  = (m_sum + int'(e.b)) % 256;
            m_idx  = m_idx + 1;
            tmo_at = rx_cyc + TMO;
        end else begin
            m_in_frame = 1'b0;
            tmo_at     = -10;
            if (e.b == m_sum[7:0]) exp_done = 1'b1;
            else m_failed = 1'b1;
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        ev_t        e;
        logic [11:0] w;
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (reset_i) begin
                m_in_frame = 1'b0;
                m_failed   = 1'b0;
                tmo_at     = -10;
                err_prev   = 1'b0;
                evq.delete();
                exp_q.delete();
                continue;
            end
            exp_done = 1'b0;
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                e = evq.pop_front();
                model_apply(e);
            end
            if (m_in_frame && cyc == tmo_at) begin
                m_in_frame = 1'b0;
                m_failed   = 1'b1;
            end

            chk("write_strobe", load_we_o, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                if (load_we_o) begin
                    chk("write_addr", load_addr_o, w[11:8]);
                    chk("write_data", load_data_o, w[7:0]);
                end
            end
            if (load_we_o) begin
                we_cnt++;
                last_we_cyc = cyc;
            end
            chk("done", load_done_o, exp_done);
            if (load_done_o) done_cnt++;
            chk("hold", cpu_hold_o, m_in_frame || m_failed);
            if (!(cyc >= tmo_at - 1 && cyc <= tmo_at + 1))
                chk("error", load_error_o, m_failed);
            if (load_error_o && !err_prev) err_rise_cyc = cyc;
            err_prev = load_error_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        uart_rx_i = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            idle(CPB);
        end
        uart_rx_i = stop_ok;
        idle(CPB);
        uart_rx_i = 1'b1;
        e.due  = cyc + 2;
        e.b    = b;
        e.ferr = !stop_ok;
        evq.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] cks);
        send_byte(SYNC, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 1'b1);
        send_byte(cks, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    load_we_o,    1'b0);
        chk({tag, "_addr"},  load_addr_o,  4'h0);
        chk({tag, "_data"},  load_data_o,  8'h00);
        chk({tag, "_hold"},  cpu_hold_o,   1'b0);
        chk({tag, "_done"},  load_done_o,  1'b0);
        chk({tag, "_error"}, load_error_o, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0, d0, lat;
        reset_i   = 1'b1;
        uart_rx_i = 1'b1;
        idle(3);
        chk_all_zero("reset");
        reset_i = 1'b0;
        idle(5);

        // Noise before sync plus a one-cycle glitch: nothing may happen.
        w0 = we_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
        uart_rx_i = 1'b0;
        idle(1);
        uart_rx_i = 1'b1;
        idle(30);
        chk("noise_writes", we_cnt - w0, 0);
        chk("noise_hold", cpu_hold_o, 1'b0);

        // Good load, checksum 0x11*(0+..+15) = 2040 -> 0xF8.
        w0 = we_cnt;
        d0 = done_cnt;
        send_frame(8'hF8);
        idle(5);
        chk("good_writes", we_cnt - w0, 16);
        chk("good_done", done_cnt - d0, 1);
        chk("good_hold", cpu_hold_o, 1'b0);
        chk("good_error", load_error_o, 1'b0);
        chk("good_last_addr", load_addr_o, 4'hF);
        chk("good_last_data", load_data_o, 8'hFF);

        // Bad checksum.
        d0 = done_cnt;
        send_frame(8'hF7);
        idle(5);
        chk("bad_done", done_cnt - d0, 0);
        chk("bad_error", load_error_o, 1'b1);
        chk("bad_hold", cpu_hold_o, 1'b1);

        // Recovery with the good frame.
        d0 = done_cnt;
        send_frame(8'hF8);
        idle(5);
        chk("recover_done", done_cnt - d0, 1);
        chk("recover_error", load_error_o, 1'b0);
        chk("recover_hold", cpu_hold_o, 1'b0);

        // Framing error on data byte 5.
        w0 = we_cnt;
        send_byte(SYNC, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b1);
        send_byte(8'h35, 1'b0);
        idle(20);
        chk("ferr_writes", we_cnt - w0, 5);
        chk("ferr_last_addr", load_addr_o, 4'h4);
        chk("ferr_error", load_error_o, 1'b1);
        chk("ferr_hold", cpu_hold_o, 1'b1);

        // Timeout after 8 data bytes.
        w0 = we_cnt;
        send_byte(SYNC, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h40 + i), 1'b1);
        idle(TMO + 60);
        chk("tmo_writes", we_cnt - w0, 8);
        chk("tmo_error", load_error_o, 1'b1);
        chk("tmo_hold", cpu_hold_o, 1'b1);
        lat = err_rise_cyc - (last_we_cyc - 1);
        n_chk++;
        if (lat < TMO - 1 || lat > TMO + 1) begin
            n_fail++;
            $display("FAIL tmo_latency: got %0d cycles, expected %0d +/-1", lat, TMO);
        end

        // Asynchronous reset in the middle of data byte 3.
        send_byte(SYNC, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h50 + i), 1'b1);
        uart_rx_i = 1'b0;
        idle(6);
        chk("pre_reset_hold", cpu_hold_o, 1'b1);
        chk("pre_reset_addr", load_addr_o, 4'h2);
        #2;
        reset_i   = 1'b1;
        uart_rx_i = 1'b1;
        #1;
        chk_all_zero("async_reset");
        idle(3);
        reset_i = 1'b0;
        idle(10);
        w0 = we_cnt;
        d0 = done_cnt;
        send_frame(8'hF8);
        idle(5);
        chk("post_reset_writes", we_cnt - w0, 16);
        chk("post_reset_done", done_cnt - d0, 1);
        chk("post_reset_hold", cpu_hold_o, 1'b0);
        chk("post_reset_error", load_error_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Serial program loader that sits directly upstream of the `eater` CPU core. It receives a framed 16-byte program image over an 8N1 UART line and writes each byte into the core's 16×8 program RAM through a dedicated write port. While a load is in progress, it holds the core in reset through the core's `reset_i`. It releases the hold only after the frame checksum verifies, and reports a failed load with a sticky error flag.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200). Must be ≥ 4 and even.
- `SYNC_BYTE`, default 8'hA5: byte that opens a frame.
- `TIMEOUT_CLKS`, default 2**20: idle cycles allowed between bytes inside a frame before the load fails.

Ports:
- `clk_i`  input  1  system clock.
- `reset_i`  input  1  asynchronous, active-high reset.
- `uart_rx_i`  input  1  asynchronous serial input, idle high, LSB first.
- `load_we_o`  output  1  RAM write strobe, one cycle per data byte.
- `load_addr_o`  output  4  RAM write address.
- `load_data_o`  output  8  RAM write data.
- `cpu_hold_o`  output  1  drives the core's `reset_i`; high while loading or after a failed load.
- `load_done_o`  output  1  one-cycle pulse on a verified load.
- `load_error_o`  output  1  sticky failure flag.

## Operation
- Frame format: `SYNC_BYTE`, 16 data bytes (address 0..15 in order), then a checksum byte equal to the 8-bit sum of the data bytes mod 256.
- Input synchronisation: `uart_rx_i` passes through a 2-flop synchroniser whose flops reset to 1. Everything below uses the synchronised signal.
- Receiver states:
  - RX_IDLE: a synced low moves to RX_START.
  - RX_START: after CLKS_PER_BIT/2 cycles, the line is re-sampled. Low moves to RX_DATA; high is a false start and returns to RX_IDLE.
  - RX_DATA: 8 samples, one every CLKS_PER_BIT cycles, shifted in LSB first.
  - RX_STOP: one sample after CLKS_PER_BIT cycles. High raises an internal `rx_valid` for one cycle; low raises an internal `rx_ferr` for one cycle and discards the byte. Either way the receiver returns to RX_IDLE.
- Loader states (outputs per state):
  - IDLE (hold=0): `rx_valid` with byte==SYNC_BYTE moves to LOAD and clears addr and sum. All other bytes and framing errors are ignored.
  - LOAD (hold=1): each `rx_valid` raises `load_we_o` with the current addr and byte, adds the byte to an 8-bit wrapping sum, and increments addr. After the write to addr 15, the state moves to CHECK. Addr never wraps within a frame.
  - CHECK (hold=1): `rx_valid` with byte==sum moves to IDLE and pulses `load_done_o`. Any other byte moves to FAIL.
  - FAIL (hold=1, error=1): `rx_valid` with byte==SYNC_BYTE moves to LOAD and clears error, addr and sum. All other bytes are ignored.
- LOAD/CHECK failure conditions, each of which moves to FAIL:
  - `rx_ferr`;
  - the inter-byte counter reaching TIMEOUT_CLKS. The counter resets on every `rx_valid` and on entry to LOAD.
- A SYNC_BYTE value received inside LOAD is ordinary data and is written to RAM.
- RAM is written as bytes arrive, so after a FAIL its contents are undefined. Hold therefore stays asserted until a later frame verifies.
- Reset (asynchronous): every output is 0 (`load_we_o`, `load_addr_o`, `load_data_o`, `cpu_hold_o`, `load_done_o`, `load_error_o`). Both state machines return to idle, and the synchroniser flops are set to 1. Reset mid-frame abandons the frame; the next byte must be a fresh SYNC_BYTE.

## Timing
- Registered outputs: all outputs are registered, with no combinational path from `uart_rx_i`.
- Bit sampling: with the synced falling edge seen at cycle t:
  - bit k (k=0..7) is sampled at t + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - the stop bit is sampled at t + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT;
  - `rx_valid`/`rx_ferr` assert the cycle after the stop-bit sample.
- Write latency: `load_we_o`, `load_addr_o` and `load_data_o` are valid exactly one cycle after `rx_valid`. Addr and data hold their values until the next write.
- Hold: `cpu_hold_o` rises one cycle after the SYNC_BYTE `rx_valid`. It falls in the same cycle that `load_done_o` pulses, one cycle after the checksum `rx_valid`.
- Error: `load_error_o` rises one cycle after the failing event and falls one cycle after the SYNC_BYTE `rx_valid` that leaves FAIL.
- Back-to-back bytes (stop bit followed immediately by a start bit) must be received without loss.

## Test plan
All scenarios use CLKS_PER_BIT=4 and TIMEOUT_CLKS=200.
- **Good load:** send A5, then data 0x00,0x11,…,0xFF, then checksum F8 → 16 `load_we_o` pulses with addr 0..15 and matching data; `cpu_hold_o` high from sync+1 until the done pulse; one `load_done_o`; `load_error_o`=0.
- **Bad checksum then recovery:** the same frame with checksum F7 → `load_error_o`=1, `cpu_hold_o` stays 1, no done. Resending the good frame → error clears one cycle after A5, then done and hold drops.
- **Pre-sync noise and false start:** bytes 00 and 5A in IDLE, plus a 1-cycle low glitch on `uart_rx_i` → no `load_we_o` and `cpu_hold_o`=0.
- **Framing error mid-load:** byte 5 sent with its stop bit low → exactly 5 writes (addr 0..4), FAIL entered, error=1, hold=1.
- **Timeout:** line idles after 8 data bytes → error rises at byte-8 `rx_valid` + 200 (±1) cycles.
- **Async reset mid-frame:** assert `reset_i` during data byte 3 → all outputs 0 immediately with no clock edge needed; after release, a full good frame loads and pulses done.
